// File: rtl/layer_sequencer.sv
// layer_sequencer: runs one fully-connected layer pass over NUM_NODES nodes.
//   Pops every node weight FIFO in lockstep while stepping the activation
//   address. It gates the node MACs, waits for the MAC pipeline to settle,
//   then presents the node results one at a time over a valid/ready port.
//
// Ports
//   clk_i         rising-edge clock
//   rst_i         synchronous, active-high reset (aborts any pass)
//   start_i       begin a pass; only sampled while idle
//   fifo_empty_i  per-node weight FIFO empty flags
//   rd_en_o       per-node FIFO pop, always all-ones or all-zeros
//   in_addr_o     activation buffer read address
//   mac_clr_o     clear all node accumulators
//   mac_en_o      accumulate weight*activation this cycle
//   out_valid_o   result for node out_sel_o is presented
//   out_ready_i   downstream accepts the presented result
//   out_sel_o     node index of the presented result
//   busy_o        high whenever not idle
//   done_o        one-cycle pulse at the end of a pass
module layer_sequencer #(
  parameter int unsigned NUM_NODES      = 4,
  parameter int unsigned NUM_INPUTS     = 8,
  parameter int unsigned IN_ADDR_WIDTH  = 3,
  parameter int unsigned NODE_SEL_WIDTH = 2,
  parameter int unsigned MAC_LATENCY    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [NUM_NODES-1:0]      fifo_empty_i,
  output logic [NUM_NODES-1:0]      rd_en_o,
  output logic [IN_ADDR_WIDTH-1:0]  in_addr_o,
  output logic                      mac_clr_o,
  output logic                      mac_en_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [NODE_SEL_WIDTH-1:0] out_sel_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned DrainW = $clog2(MAC_LATENCY + 1);

  localparam logic [IN_ADDR_WIDTH-1:0]  LastIn   = IN_ADDR_WIDTH'(NUM_INPUTS - 1);
  localparam logic [NODE_SEL_WIDTH-1:0] LastNode = NODE_SEL_WIDTH'(NUM_NODES - 1);
  localparam logic [DrainW-1:0]         LastDrain = DrainW'(MAC_LATENCY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StAccum,
    StDrain,
    StWrite,
    StDone
  } state_e;

  state_e                    state_q, state_d;
  logic [IN_ADDR_WIDTH-1:0]  in_idx_q, in_idx_d;
  logic [NODE_SEL_WIDTH-1:0] node_idx_q, node_idx_d;
  logic [DrainW-1:0]         drain_cnt_q, drain_cnt_d;
  logic                      mac_en_q;
  logic                      pop;

  always_comb begin
    state_d     = state_q;
    in_idx_d    = in_idx_q;
    node_idx_d  = node_idx_q;
    drain_cnt_d = drain_cnt_q;
    pop         = 1'b0;
    mac_clr_o   = 1'b0;
    out_valid_o = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StClear;
      end
      StClear: begin
        mac_clr_o = 1'b1;
        in_idx_d  = '0;
        state_d   = StAccum;
      end
      StAccum: begin
        // Any empty FIFO stalls the whole layer so no FIFO is ever underflowed.
        pop = ~|fifo_empty_i;
        if (pop) begin
          if (in_idx_q == LastIn) begin
            in_idx_d    = '0;
            drain_cnt_d = '0;
            state_d     = StDrain;
          end else begin
            in_idx_d = in_idx_q + 1'b1;
          end
        end
      end
      StDrain: begin
        // The final mac_en lands in the first drain cycle; the result is
        // stable MAC_LATENCY cycles later, i.e. on WRITE entry.
        if (drain_cnt_q == LastDrain) begin
          node_idx_d = '0;
          state_d    = StWrite;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      StWrite: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          if (node_idx_q == LastNode) begin
            node_idx_d = '0;
            state_d    = StDone;
          end else begin
            node_idx_d = node_idx_q + 1'b1;
          end
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      in_idx_q    <= '0;
      node_idx_q  <= '0;
      drain_cnt_q <= '0;
      mac_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_idx_q    <= in_idx_d;
      node_idx_q  <= node_idx_d;
      drain_cnt_q <= drain_cnt_d;
      // FIFO and activation buffer both have one cycle of read latency.
      mac_en_q    <= pop;
    end
  end

  assign rd_en_o   = {NUM_NODES{pop}};
  assign in_addr_o = in_idx_q;
  assign out_sel_o = node_idx_q;
  assign mac_en_o  = mac_en_q;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b1;
  logic [3:0] fifo_empty = 4'b0000;
  logic       out_ready = 1'b1;
  logic [3:0] rd_en;
  logic [2:0] in_addr;
  logic       mac_clr, mac_en, out_valid, busy, done;
  logic [1:0] out_sel;

  int n_cmp = 0;
  int n_err = 0;
  int pops  = 0;
  int macs  = 0;

  always #5 clk = ~clk;

  layer_sequencer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .fifo_empty_i (fifo_empty),
    .rd_en_o      (rd_en),
    .in_addr_o    (in_addr),
    .mac_clr_o    (mac_clr),
    .mac_en_o     (mac_en),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_sel_o    (out_sel),
    .busy_o       (busy),
    .done_o       (done)
  );

  typedef struct packed {
    logic        rst;
    logic        start;
    logic [3:0]  empty;
    logic        ready;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic r, input logic s, input logic [3:0] e,
                              input logic rdy, input logic [3:0] rd, input logic [2:0] a,
                              input logic c, input logic en, input logic val,
                              input logic [1:0] sel, input logic b, input logic d);
    vec_t t;
    t.rst   = r;
    t.start = s;
    t.empty = e;
    t.ready = rdy;
    t.exp   = {rd, a, c, en, val, sel, b, d};
    return t;
  endfunction

  function automatic logic [13:0] outs();
    return {rd_en, in_addr, mac_clr, mac_en, out_valid, out_sel, busy, done};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs just after the edge, observe at the falling edge.
  task automatic cyc(input logic r, input logic s, input logic [3:0] e, input logic rdy);
    @(posedge clk);
    #1;
    rst        = r;
    start      = s;
    fifo_empty = e;
    out_ready  = rdy;
    @(negedge clk);
    if (rd_en == 4'hF) pops++;
    if (mac_en) macs++;
    if (rd_en != 4'h0) chk("no_underflow_pop", {28'd0, fifo_empty}, 32'd0);
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc(1'b0, 1'b0, 4'h0, 1'b1);
      seen = done;
    end
    chk("done_within_bound", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    // Reset with start held, then one unstalled pass, cycle by cycle.
    vecs[0]  = mk(1, 1, 4'h0, 1, 4'h0, 3'd0, 0, 0, 0, 2'd0, 0, 0);
    vecs[1]  = mk(1, 1, 4'h0, 1, 4'h0, 3'd0, 0, 0, 0, 2'd0, 0, 0);
    vecs[2]  = mk(0, 1, 4'h0, 1, 4'h0, 3'd0, 0, 0, 0, 2'd0, 0, 0);
    vecs[3]  = mk(0, 0, 4'h0, 1, 4'h0, 3'd0, 1, 0, 0, 2'd0, 1, 0);
    vecs[4]  = mk(0, 0, 4'h0, 1, 4'hF, 3'd0, 0, 0, 0, 2'd0, 1, 0);
    vecs[5]  = mk(0, 0, 4'h0, 1, 4'hF, 3'd1, 0, 1, 0, 2'd0, 1, 0);
    vecs[6]  = mk(0, 0, 4'h0, 1, 4'hF, 3'd2, 0, 1, 0, 2'd0, 1, 0);
    vecs[7]  = mk(0, 0, 4'h0, 1, 4'hF, 3'd3, 0, 1, 0, 2'd0, 1, 0);
    vecs[8]  = mk(0, 0, 4'h0, 1, 4'hF, 3'd4, 0, 1, 0, 2'd0, 1, 0);
    vecs[9]  = mk(0, 0, 4'h0, 1, 4'hF, 3'd5, 0, 1, 0, 2'd0, 1, 0);
    vecs[10] = mk(0, 0, 4'h0, 1, 4'hF, 3'd6, 0, 1, 0, 2'd0, 1, 0);
    vecs[11] = mk(0, 0, 4'h0, 1, 4'hF, 3'd7, 0, 1, 0, 2'd0, 1, 0);
    vecs[12] = mk(0, 0, 4'h0, 1, 4'h0, 3'd0, 0, 1, 0, 2'd0, 1, 0);
    vecs[13] = mk(0, 0, 4'h0, 1, 4'h0, 3'd0, 0, 0, 0, 2'd0, 1, 0);
    vecs[14] = mk(0, 0, 4'h0, 1, 4'h0, 3'd0, 0, 0, 1, 2'd0, 1, 0);
    vecs[15] = mk(0, 0, 4'h0, 1, 4'h0, 3'd0, 0, 0, 1, 2'd1, 1, 0);
    vecs[16] = mk(0, 0, 4'h0, 1, 4'h0, 3'd0, 0, 0, 1, 2'd2, 1, 0);
    vecs[17] = mk(0, 0, 4'h0, 1, 4'h0, 3'd0, 0, 0, 1, 2'd3, 1, 0);
    vecs[18] = mk(0, 0, 4'h0, 1, 4'h0, 3'd0, 0, 0, 0, 2'd0, 1, 1);
    vecs[19] = mk(0, 0, 4'h0, 1, 4'h0, 3'd0, 0, 0, 0, 2'd0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      cyc(vecs[i].rst, vecs[i].start, vecs[i].empty, vecs[i].ready);
      chk($sformatf("vec%0d", i), {18'd0, outs()}, {18'd0, vecs[i].exp});
    end

    // FIFO 2 empty for three cycles at in_idx 5.
    pops = 0;
    macs = 0;
    cyc(0, 1, 4'h0, 1);
    cyc(0, 0, 4'h0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 4'h0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 4'b0100, 1);
      chk("stall_rd_en", {28'd0, rd_en}, 32'd0);
      chk("stall_in_addr", {29'd0, in_addr}, 32'd5);
    end
    for (int i = 5; i < 8; i++) begin
      cyc(0, 0, 4'h0, 1);
      chk("resume_pop", {25'd0, rd_en, in_addr}, {25'd0, 4'hF, 3'(i)});
    end
    wait_done();
    chk("stall_pop_count", pops, 8);
    chk("stall_mac_count", macs, 8);

    // Back-pressure while node 2 is presented.
    cyc(0, 1, 4'h0, 1);
    for (int i = 0; i < 11; i++) cyc(0, 0, 4'h0, 1);
    cyc(0, 0, 4'h0, 1);
    chk("bp_sel0", {29'd0, out_valid, out_sel}, 32'b100);
    cyc(0, 0, 4'h0, 1);
    chk("bp_sel1", {29'd0, out_valid, out_sel}, 32'b101);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 4'h0, 0);
      chk("bp_hold_sel2", {29'd0, out_valid, out_sel}, 32'b110);
    end
    cyc(0, 0, 4'h0, 1);
    chk("bp_accept_sel2", {29'd0, out_valid, out_sel}, 32'b110);
    cyc(0, 0, 4'h0, 1);
    chk("bp_sel3", {29'd0, out_valid, out_sel}, 32'b111);
    cyc(0, 0, 4'h0, 1);
    chk("bp_done", {30'd0, busy, done}, 32'b11);

    // Reset during ACCUM at in_idx 3 aborts the pass.
    cyc(0, 1, 4'h0, 1);
    cyc(0, 0, 4'h0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 4'h0, 1);
    cyc(1, 0, 4'h0, 1);
    chk("abort_at_idx3", {28'd0, busy, in_addr}, 32'b1011);
    cyc(0, 0, 4'h0, 1);
    chk("abort_outputs_zero", {18'd0, outs()}, 32'd0);
    pops = 0;
    macs = 0;
    cyc(0, 1, 4'h0, 1);
    wait_done();
    chk("post_abort_pops", pops, 8);
    chk("post_abort_macs", macs, 8);

    // start held high: passes of 16 busy cycles separated by one idle cycle.
    for (int i = 0; i < 34; i++) begin
      cyc(0, 1, 4'h0, 1);
      chk($sformatf("b2b_c%0d", i), {29'd0, busy, done, mac_clr},
          {29'd0, (i % 17) != 0, (i % 17) == 16, (i % 17) == 1});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
